mk14_mem_arbiter: RTL and testbench
===================================

// Module: mk14_mem_arbiter
// PURPOSE
//  Shares the single-port MK14 RAM between the SC/MP CPU bus and the VDU display fetch.
//  The VDU has absolute priority and sees the RAM unchanged: 1-cycle read latency, never stalled.
//  CPU accesses use a req/ack handshake and are issued only in cycles where the VDU is not reading.
//  Stall statistics and a starvation flag are kept for debug. Sits between vdu/cpu and the RAM.
// PARAMETERS
//  STARVE_LIMIT  64  blocked PEND cycles after which cpu_starved asserts
// PORTS
//  clk_pix        in   1   single clock, RAM/VDU/CPU domain
//  rst_pix        in   1   synchronous reset, active-high
//  vdu_read_en    in   1   VDU read request this cycle
//  vdu_read_addr  in   16  VDU read address
//  vdu_data       out  8   = mem_rdata, valid the cycle after vdu_read_en
//  cpu_req        in   1   CPU access request, held high until cpu_ack
//  cpu_we         in   1   1 = write, 0 = read
//  cpu_addr       in   16  CPU address
//  cpu_wdata      in   8   CPU write data
//  cpu_ack        out  1   one-cycle completion pulse
//  cpu_rdata      out  8   registered read data, valid from cpu_ack, held until next read
//  mem_en         out  1   RAM enable
//  mem_we         out  1   RAM write enable
//  mem_addr       out  16  RAM address
//  mem_wdata      out  8   RAM write data
//  mem_rdata      in   8   RAM read data, 1-cycle synchronous latency
//  cpu_starved    out  1   CPU blocked >= STARVE_LIMIT cycles in current request
//  stall_max      out  16  longest blocked time seen, in cycles, since reset
// BEHAVIOUR
//  Reset (rst_pix=1): state IDLE; cpu_ack=0, cpu_rdata=0, stall_max=0, wait_cnt=0, cpu_starved=0.
//   mem_en=0 and mem_we=0 while rst_pix=1. Abandons any access in flight, no ack.
//   A write already issued stays committed in RAM.
//  FSM, registered: IDLE -> PEND -> (RDATA) -> DONE -> IDLE.
//   IDLE: if cpu_req=1, latch cpu_we/addr/wdata into regs, clear wait_cnt, go to PEND.
//   PEND: if vdu_read_en=1, CPU is blocked. wait_cnt +1, saturating at 0xFFFF. Stay.
//         else issue from latched regs (mem_en=1, mem_we=we). Go to RDATA if read, DONE if write.
//   RDATA: cpu_rdata <= mem_rdata. Go to DONE.
//   DONE: cpu_ack=1 (state decode, exactly 1 cycle). Go to IDLE.
//  Mem mux, combinational: vdu_read_en=1 -> mem_en=1, mem_we=0, mem_addr=vdu_read_addr.
//   Else PEND issue -> latched CPU regs. Else mem_en=0, mem_we=0.
//   mem_addr/mem_wdata hold latched CPU values when idle.
//  Uncontended latency, counted from the cpu_req cycle in IDLE: read ack at +3, write ack at +2.
//  CPU must drop cpu_req the cycle after cpu_ack. A req still high in IDLE is a new request.
//  A req dropped before ack is ignored: the latched access completes and acks.
//  Same-cycle VDU read and CPU write to the same address: VDU read wins and returns old data.
//   The write is issued later.
//  On leaving PEND: stall_max <= max(stall_max, wait_cnt).
//  cpu_starved = (state==PEND) && (wait_cnt >= STARVE_LIMIT).
// STRUCTURE
//  Shared package mk14_mem_pkg:
//   ADDR_W=16, DATA_W=8
//   typedef enum logic [1:0] {IDLE, PEND, RDATA, DONE} arb_state_t
//  Sub-module mk14_stall_mon holds wait_cnt, stall_max and cpu_starved.
//   Inputs: clk_pix, rst_pix, start (IDLE accept), blocked, leave (PEND exit).
//  Everything else sits in mk14_mem_arbiter.
// TESTING
//  1. VDU idle. RAM[0x0F20]=0xA5. CPU read 0x0F20 at cycle 0.
//     -> mem_en/addr=0x0F20 at cycle 1, cpu_ack at cycle 3, cpu_rdata=0xA5, stall_max=0.
//  2. CPU write 0x0F05<-0x3C during a 16-cycle vdu_read_en burst over 0x0F00..0x0F0F.
//     -> every vdu_data correct at +1. Write issued the first cycle after the burst.
//     -> ack the cycle after issue. stall_max=16 (0x0010).
//  3. CPU write 0x0F03<-0x77 and VDU read 0x0F03 in the same PEND cycle.
//     -> vdu_data = old value. Write issues next free cycle. Next VDU read of 0x0F03 -> 0x77.
//  4. STARVE_LIMIT=64, vdu_read_en held 70 cycles with a CPU read pending.
//     -> cpu_starved rises at wait_cnt=64, falls on issue, stall_max=70.
//  5. rst_pix pulsed while in RDATA.
//     -> no cpu_ack, all outputs at reset values. Next CPU read completes normally in 3 cycles.
//  6. cpu_req dropped while in PEND.
//     -> access still issues, one cpu_ack. No second access.

Source files
------------

// File: rtl/mk14_mem_pkg.sv
// mk14_mem_pkg: shared widths and arbiter state encoding for the MK14 RAM arbiter
package mk14_mem_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, PEND, RDATA, DONE} arb_state_t;
endpackage

// File: rtl/mk14_stall_mon.sv
// mk14_stall_mon: per-request CPU wait counter, worst-case stall since reset and starvation flag
module mk14_stall_mon #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    input  logic        start,
    input  logic        blocked,
    input  logic        leave,
    input  logic        pend,
    output logic        cpu_starved,
    output logic [15:0] stall_max
);
    logic [15:0] wait_cnt_q, wait_cnt_d, stall_max_q, stall_max_d;
    always_comb begin
        wait_cnt_d  = start ? 16'd0 : (blocked && wait_cnt_q != 16'hFFFF) ? wait_cnt_q + 16'd1 : wait_cnt_q;
        stall_max_d = (leave && wait_cnt_q > stall_max_q) ? wait_cnt_q : stall_max_q;
    end
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            wait_cnt_q  <= 16'd0;
            stall_max_q <= 16'd0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            stall_max_q <= stall_max_d;
        end
    end
    assign stall_max   = stall_max_q;
    assign cpu_starved = pend && !rst_pix && (wait_cnt_q >= 16'(STARVE_LIMIT));
endmodule

// File: rtl/mk14_mem_arbiter.sv
// mk14_mem_arbiter: shares the single-port RAM between the VDU (absolute priority) and the CPU handshake
module mk14_mem_arbiter import mk14_mem_pkg::*; #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              vdu_read_en,
    input  logic [ADDR_W-1:0] vdu_read_addr,
    output logic [DATA_W-1:0] vdu_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_starved,
    output logic [15:0]       stall_max
);
    arb_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              accept, blocked, issue;
    assign accept  = state_q == IDLE && cpu_req;
    assign blocked = state_q == PEND && vdu_read_en;
    assign issue   = state_q == PEND && !vdu_read_en && !rst_pix;
    always_comb begin
        we_d    = accept ? cpu_we : we_q;
        addr_d  = accept ? cpu_addr : addr_q;
        wdata_d = accept ? cpu_wdata : wdata_q;
        rdata_d = state_q == RDATA ? mem_rdata : rdata_q;
        state_d = accept ? PEND :
                  issue ? (we_q ? DONE : RDATA) :
                  state_q == RDATA ? DONE :
                  state_q == DONE ? IDLE : state_q;
    end
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    // VDU owns the port whenever it reads; the CPU only ever gets leftover cycles
    assign mem_en    = !rst_pix && (vdu_read_en || issue);
    assign mem_we    = issue && we_q;
    assign mem_addr  = vdu_read_en ? vdu_read_addr : addr_q;
    assign mem_wdata = wdata_q;
    assign vdu_data  = mem_rdata;
    assign cpu_ack   = state_q == DONE && !rst_pix;
    assign cpu_rdata = rdata_q;
    mk14_stall_mon #(.STARVE_LIMIT(STARVE_LIMIT)) u_stall_mon (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .start      (accept),
        .blocked    (blocked),
        .leave      (issue),
        .pend       (state_q == PEND),
        .cpu_starved(cpu_starved),
        .stall_max  (stall_max)
    );
endmodule

// File: tb/tb_mk14_mem_arbiter.sv
// tb_mk14_mem_arbiter: randomized scoreboard bench for the MK14 RAM arbiter
module tb_mk14_mem_arbiter;
    logic        clk_pix = 1'b0, rst_pix = 1'b1, vdu_read_en = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] vdu_read_addr = '0, cpu_addr = '0, mem_addr, stall_max;
    logic [7:0]  cpu_wdata = '0, vdu_data, cpu_rdata, mem_wdata, mem_rdata = '0;
    logic        cpu_ack, mem_en, mem_we, cpu_starved;
    always #5 clk_pix = ~clk_pix;
    mk14_mem_arbiter #(.STARVE_LIMIT(64)) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix),
        .vdu_read_en(vdu_read_en), .vdu_read_addr(vdu_read_addr), .vdu_data(vdu_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_starved(cpu_starved), .stall_max(stall_max)
    );
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    // RAM: synchronous 1-cycle read, untouched locations read as init_val
    logic [7:0] ram [0:65535];
    bit         wr_seen [0:65535];
    always @(posedge clk_pix) begin
        if (mem_en && mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            wr_seen[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we) mem_rdata <= wr_seen[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end
    typedef struct {bit en; bit we; bit st; bit regs; logic [15:0] addr; logic [7:0] wd; logic [7:0] rd; logic [15:0] smax;} cyc_t;
    typedef struct {int cyc; logic [7:0] rd; logic [15:0] smax;} ack_t;
    typedef struct {int cyc; logic [7:0] d;} vdu_t;
    cyc_t q_cyc[$];
    ack_t q_ack[$];
    vdu_t q_vdu[$];
    int chk_cnt = 0, pass_cnt = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        else pass_cnt++;
    endtask
    // Reference model: CPU access issues on the first non-VDU cycle after acceptance
    logic [7:0]  model [0:65535];
    int          n = 0, cyc = 0, t0 = 0, k = 0, ack_c = 0, next_ok = 0, burst = 0;
    bit          busy = 0, issued = 0, is_wr = 0, early = 0, post_rst = 0;
    logic [15:0] a = '0, smax = '0;
    logic [7:0]  wd = '0, last_rd = '0;
    task automatic step(input bit vdu_ok, input bit rst_now, input bit cpu_ok, input bit force_rd);
        cyc_t e;
        bit   pend;
        @(posedge clk_pix);
        #1;
        cyc = n;
        rst_pix = rst_now;
        if (busy && issued && n > ack_c) busy = 0;
        if (!busy && n >= next_ok && !rst_now && (force_rd || (cpu_ok && $urandom_range(0, 2) == 0))) begin
            busy   = 1;
            issued = 0;
            t0     = n;
            is_wr  = force_rd ? 1'b0 : 1'($urandom_range(0, 1));
            early  = !force_rd && $urandom_range(0, 3) == 0;
            k      = $urandom_range(1, 4);
            a      = 16'h0F00 + 16'($urandom_range(0, 63));
            wd     = 8'($urandom);
        end
        if (vdu_ok && burst == 0 && $urandom_range(0, 2) == 0)
            burst = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(1, 18);
        if (!vdu_ok) burst = 0;
        vdu_read_en = burst > 0;
        if (burst > 0) burst--;
        vdu_read_addr = 16'h0F00 + 16'($urandom_range(0, 63));
        cpu_req   = busy && (!early || n < t0 + k) && (!issued || n <= ack_c);
        cpu_we    = (busy && n == t0) ? is_wr : 1'($urandom_range(0, 1));
        cpu_addr  = (busy && n == t0) ? a : 16'($urandom);
        cpu_wdata = (busy && n == t0) ? wd : 8'($urandom);
        pend = busy && !issued && n > t0 && !rst_now;
        e = '{default: '0};
        e.st = pend && (n - t0 - 1) >= 64;
        if (vdu_read_en) begin
            e.en   = 1;
            e.addr = vdu_read_addr;
            q_vdu.push_back('{n + 1, model[vdu_read_addr]});
        end else if (pend) begin
            issued  = 1;
            ack_c   = n + (is_wr ? 1 : 2);
            next_ok = ack_c + 2;
            if (16'(n - t0 - 1) > smax) smax = 16'(n - t0 - 1);
            if (is_wr) model[a] = wd;
            else last_rd = model[a];
            e.en   = 1;
            e.we   = is_wr;
            e.addr = a;
            e.wd   = wd;
            q_ack.push_back('{ack_c, last_rd, smax});
        end
        e.regs = post_rst;
        e.rd   = last_rd;
        e.smax = smax;
        q_cyc.push_back(e);
        if (rst_now) begin
            busy    = 0;
            smax    = '0;
            last_rd = '0;
            next_ok = n + 2;
            q_ack.delete();
        end
        post_rst = rst_now;
        n++;
    endtask
    cyc_t mc;
    ack_t ma;
    vdu_t mv;
    bit   exp_ack;
    always @(negedge clk_pix) begin
        if (q_cyc.size() > 0) begin
            mc = q_cyc.pop_front();
            chk("mem_en", 32'(mem_en), 32'(mc.en));
            if (mc.en) begin
                chk("mem_addr", 32'(mem_addr), 32'(mc.addr));
                chk("mem_we", 32'(mem_we), 32'(mc.we));
            end
            if (mc.en && mc.we) chk("mem_wdata", 32'(mem_wdata), 32'(mc.wd));
            chk("cpu_starved", 32'(cpu_starved), 32'(mc.st));
            if (mc.regs) begin
                chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(mc.rd));
                chk("rst_stall_max", 32'(stall_max), 32'(mc.smax));
            end
            exp_ack = q_ack.size() > 0 && q_ack[0].cyc == cyc;
            chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
            if (exp_ack) begin
                ma = q_ack.pop_front();
                chk("cpu_rdata", 32'(cpu_rdata), 32'(ma.rd));
                chk("stall_max", 32'(stall_max), 32'(ma.smax));
            end
            if (q_vdu.size() > 0 && q_vdu[0].cyc == cyc) begin
                mv = q_vdu.pop_front();
                chk("vdu_data", 32'(vdu_data), 32'(mv.d));
            end
        end
    end
    initial begin
        for (int i = 0; i < 65536; i++) model[i] = init_val(16'(i));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) step(1, 0, 1, 0);
        for (int i = 0; i < 300 && (busy || n < next_ok); i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) step(1, 0, 1, 0);
        for (int i = 0; i < 300 && (busy || n < next_ok); i++) step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        @(negedge clk_pix);
        #1;
        chk("ack_drain", 32'(q_ack.size()), 32'd0);
        chk("vdu_drain", 32'(q_vdu.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
